// File: rtl/fire_zone_scheduler.sv
// Four-zone fire extinguisher scheduler: synchronize, debounce, round-robin grant, valve-before-pump sequencing.
// Optional feature macro FIRE_SCHED_MANUAL_ACK_EN latches the alarm until an operator ack with no zone pending.
module fire_zone_scheduler #(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int DISCHARGE_CYCLES = 16,
  parameter int COOLDOWN_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fire_sensor,
  input  logic       ack,
  output logic       extinguisher,
  output logic [3:0] valve,
  output logic       alarm,
  output logic [3:0] pending
);

  localparam int TMAX = (DISCHARGE_CYCLES > COOLDOWN_CYCLES) ? DISCHARGE_CYCLES : COOLDOWN_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OPEN      = 2'd1,
    DISCHARGE = 2'd2,
    COOLDOWN  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [3:0]      sync1_r, sync2_r;
  logic [CW-1:0]   cnt_r [4];
  logic [3:0]      pending_r, pending_s, set_s, clr_s;
  logic [1:0]      grant_r, grant_s, next_zone_s;
  logic            found_s;
  logic [TW-1:0]   timer_r, timer_s;
  logic [3:0]      valve_r, valve_s;
  logic            ext_r, ext_s, alarm_r, alarm_s;

  function automatic logic [3:0] zone_onehot(input logic [1:0] z);
    return 4'b0001 << z;
  endfunction

  // two-flop synchronizer for the raw sensors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= fire_sensor;
      sync2_r <= sync1_r;
    end
  end

  // saturating per-zone debounce counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!sync2_r[i])                           cnt_r[i] <= '0;
        else if (cnt_r[i] != CW'(DEBOUNCE_CYCLES)) cnt_r[i] <= cnt_r[i] + CW'(1);
        else                                       cnt_r[i] <= cnt_r[i];
      end
    end
  end

  // qualification strobe: counter about to reach the debounce threshold
  always_comb begin
    set_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      set_s[i] = sync2_r[i] && (cnt_r[i] == CW'(DEBOUNCE_CYCLES - 1));
    end
  end

  // round-robin pick: first pending zone scanning upward from last grant + 1
  always_comb begin
    next_zone_s = grant_r;
    found_s     = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found_s && pending_r[grant_r + 2'(k)]) begin
        next_zone_s = grant_r + 2'(k);
        found_s     = 1'b1;
      end else begin
        found_s     = found_s;
      end
    end
  end

  // FSM next state, timer and service-complete clear
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    timer_s = timer_r;
    clr_s   = 4'b0000;
    case (state_r)
      IDLE: begin
        if (|pending_r) begin
          state_s = OPEN;
          grant_s = next_zone_s;
          timer_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      OPEN: begin
        state_s = DISCHARGE;
        timer_s = '0;
      end
      DISCHARGE: begin
        if (timer_r == TW'(DISCHARGE_CYCLES - 1)) begin
          state_s = COOLDOWN;
          timer_s = '0;
          clr_s   = zone_onehot(grant_r) & ~sync2_r;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      COOLDOWN: begin
        if (timer_r == TW'(COOLDOWN_CYCLES - 1)) begin
          state_s = IDLE;
          timer_s = '0;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        timer_s = '0;
      end
    endcase
  end

  // pending/alarm/output next values; outputs follow the next state so they are registered
  always_comb begin
    pending_s = (pending_r & ~clr_s) | set_s;
`ifdef FIRE_SCHED_MANUAL_ACK_EN
    if (|pending_s)                      alarm_s = 1'b1;
    else if (ack && (pending_r == 4'b0)) alarm_s = 1'b0;
    else                                 alarm_s = alarm_r;
`else
    alarm_s = (|pending_s) | (|pending_r);
`endif
    if ((state_s == OPEN) || (state_s == DISCHARGE)) valve_s = zone_onehot(grant_s);
    else                                             valve_s = 4'b0000;
    ext_s = (state_s == DISCHARGE);
  end

`ifndef FIRE_SCHED_MANUAL_ACK_EN
  logic unused_ack_s;
  assign unused_ack_s = ack;
`endif

  // state and output registers; grant pointer resets to 3 so zone 0 is served first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      grant_r   <= 2'd3;
      timer_r   <= '0;
      pending_r <= 4'b0000;
      alarm_r   <= 1'b0;
      valve_r   <= 4'b0000;
      ext_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      timer_r   <= timer_s;
      pending_r <= pending_s;
      alarm_r   <= alarm_s;
      valve_r   <= valve_s;
      ext_r     <= ext_s;
    end
  end

  assign extinguisher = ext_r;
  assign valve        = valve_r;
  assign alarm        = alarm_r;
  assign pending      = pending_r;

endmodule

// File: tb/tb_fire_zone_scheduler.sv
// Scoreboard bench for fire_zone_scheduler: a service-schedule reference model predicts outputs per cycle,
// a negedge monitor compares them. Honours FIRE_SCHED_MANUAL_ACK_EN like the design.
module tb_fire_zone_scheduler;
  localparam int DEB  = 4;
  localparam int DIS  = 16;
  localparam int COOL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] fire_sensor;
  logic       ack;
  logic       extinguisher;
  logic [3:0] valve;
  logic       alarm;
  logic [3:0] pending;

  fire_zone_scheduler #(.DEBOUNCE_CYCLES(DEB), .DISCHARGE_CYCLES(DIS), .COOLDOWN_CYCLES(COOL)) dut (
    .clk(clk), .reset(reset), .fire_sensor(fire_sensor), .ack(ack),
    .extinguisher(extinguisher), .valve(valve), .alarm(alarm), .pending(pending)
  );

  always #5 clk = ~clk;

  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model: sync stages, high-run lengths, pending flags, and a service timeline
  int m_s1[4], m_s2[4], m_run[4], m_pend[4];
  int m_busy, m_t, m_gz, m_last, m_alarm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 4; z++) begin
      m_s1[z] = 0; m_s2[z] = 0; m_run[z] = 0; m_pend[z] = 0;
    end
    m_busy = 0; m_t = 0; m_gz = 0; m_last = 3; m_alarm = 0;
  endtask

  task automatic model_step();
    int pre_s2[4];
    int set[4];
    int old_any, new_any, pick;
    logic [3:0] v, p;
    logic e;
    if (!reset) begin
      model_reset();
      exp_q.push_back(10'd0);
      return;
    end
    old_any = 0;
    for (int z = 0; z < 4; z++) begin
      pre_s2[z] = m_s2[z];
      if (m_pend[z] != 0) old_any = 1;
    end
    for (int z = 0; z < 4; z++) begin
      m_run[z] = pre_s2[z] ? ((m_run[z] > DEB) ? DEB + 1 : m_run[z] + 1) : 0;
      set[z]   = (m_run[z] == DEB) ? 1 : 0;
      m_s2[z]  = m_s1[z];
      m_s1[z]  = fire_sensor[z];
    end
    if (m_busy == 0) begin
      if (old_any != 0) begin
        pick = -1;
        for (int k = 1; k <= 4; k++) begin
          if (pick < 0 && m_pend[(m_last + k) % 4] != 0) pick = (m_last + k) % 4;
        end
        m_busy = 1; m_t = 0; m_gz = pick; m_last = pick;
      end
    end else begin
      m_t++;
      if (m_t == DIS + 1 && pre_s2[m_gz] == 0) m_pend[m_gz] = 0;
      if (m_t == DIS + COOL + 1) m_busy = 0;
    end
    new_any = 0;
    for (int z = 0; z < 4; z++) begin
      if (set[z] != 0) m_pend[z] = 1;
      if (m_pend[z] != 0) new_any = 1;
      p[z] = (m_pend[z] != 0);
    end
`ifdef FIRE_SCHED_MANUAL_ACK_EN
    if (new_any != 0)               m_alarm = 1;
    else if (ack && old_any == 0)   m_alarm = 0;
`else
    m_alarm = (new_any != 0 || old_any != 0) ? 1 : 0;
`endif
    v = (m_busy != 0 && m_t <= DIS) ? (4'b0001 << m_gz) : 4'b0000;
    e = (m_busy != 0 && m_t >= 1 && m_t <= DIS);
    exp_q.push_back({e, v, m_alarm[0], p});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // asynchronous reset mid-cycle: outputs must drop before the next edge
  task automatic async_reset(input string tag);
    reset = 1'b0;
    model_reset();
    if (exp_q.size() > 0) exp_q[$] = 10'd0;
    #1;
    check({tag, "_ext"},   {31'd0, extinguisher}, 32'd0);
    check({tag, "_valve"}, {28'd0, valve},        32'd0);
    check({tag, "_alarm"}, {31'd0, alarm},        32'd0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  // monitor: compare every predicted cycle away from the active edge
  always @(negedge clk) begin
    logic [9:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs{ext,valve,alarm,pending}", {22'd0, extinguisher, valve, alarm, pending}, {22'd0, e});
      check("valve_at_most_one_hot", {31'd0, ($countones(valve) <= 1)}, 32'd1);
    end
  end

  initial begin
    reset = 1'b0;
    fire_sensor = 4'b0000;
    ack = 1'b0;
    model_reset();
    idle(3);
    reset = 1'b1;
    idle(2);

    // zone 0 held through the first discharge end, so it is regranted
    fire_sensor = 4'b0001;
    idle(40);
    fire_sensor = 4'b0000;
    idle(40);

    // 3-cycle glitch on zone 2 never qualifies
    fire_sensor = 4'b0100;
    idle(3);
    fire_sensor = 4'b0000;
    idle(15);

    // serve zone 1 alone, then zones 1 and 3 together: 3 must come first
    fire_sensor = 4'b0010;
    idle(8);
    fire_sensor = 4'b0000;
    idle(40);
    fire_sensor = 4'b1010;
    idle(8);
    fire_sensor = 4'b0000;
    idle(70);

    // operator ack after service with no pending zone
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    idle(5);

    // ack during service is ignored; then reset at discharge cycle 8
    fire_sensor = 4'b0001;
    idle(10);
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    idle(4);
    async_reset("reset_mid_discharge");
    idle(20);
    fire_sensor = 4'b0000;
    idle(40);

    // randomized sensors, acks and occasional resets
    for (int c = 0; c < 600; c++) begin
      for (int z = 0; z < 4; z++) begin
        if ($urandom_range(0, 11) == 0) fire_sensor[z] = ~fire_sensor[z];
      end
      ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) async_reset("reset_random");
      else tick();
    end
    fire_sensor = 4'b0000;
    ack = 1'b0;
    idle(60);
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    idle(3);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fire_zone_scheduler.md
FIRE_ZONE_SCHEDULER -- requirements
Module: fire_zone_scheduler

Interface
- REQ-001: The module SHALL have a parameter DEBOUNCE_CYCLES, default 4: consecutive high samples needed to qualify a zone sensor.
- REQ-002: The module SHALL have a parameter DISCHARGE_CYCLES, default 16: number of cycles the extinguisher output is active per grant.
- REQ-003: The module SHALL have a parameter COOLDOWN_CYCLES, default 4: number of idle cycles after a discharge before the next grant.
- REQ-004: Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-005: Port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-006: Port fire_sensor, input, 4 bits: per-zone raw fire sensors, active-high, asynchronous to clk.
- REQ-007: Port ack, input, 1 bit: operator alarm acknowledge, active-high (used only when REQ-030 applies).
- REQ-008: Port extinguisher, output, 1 bit: shared pump drive, active-high.
- REQ-009: Port valve, output, 4 bits: one-hot zone valve select; SHALL be all-zero when no zone is granted.
- REQ-010: Port alarm, output, 1 bit: store-wide fire alarm.
- REQ-011: Port pending, output, 4 bits: qualified zones awaiting or receiving service.

Function
- REQ-012: fire_sensor SHALL be passed through a 2-flop synchronizer before any other use.
- REQ-013: Each zone SHALL have a saturating debounce counter that increments while its synchronized sensor is high and clears to 0 on any low sample.
- REQ-014: pending[i] SHALL be set on the edge at which counter i reaches DEBOUNCE_CYCLES.
- REQ-015: The FSM SHALL have exactly four states: IDLE, OPEN, DISCHARGE, COOLDOWN.
- REQ-016: IDLE->OPEN SHALL occur when any pending bit is set; the granted zone SHALL be chosen round-robin, starting from the zone after the last granted zone (zone 0 first after reset).
- REQ-017: OPEN SHALL last exactly 1 cycle; in OPEN, valve SHALL be asserted and extinguisher SHALL be 0 (valve-before-pump ordering).
- REQ-018: DISCHARGE SHALL last exactly DISCHARGE_CYCLES cycles, with valve and extinguisher both asserted.
- REQ-019: On DISCHARGE exit, pending[granted] SHALL clear if the zone's synchronized sensor is low; otherwise it SHALL stay set and be re-arbitrated normally.
- REQ-020: COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles with valve=0 and extinguisher=0, then return to IDLE.
- REQ-021: Sensors qualifying during OPEN, DISCHARGE or COOLDOWN SHALL set pending and wait; they SHALL never preempt the active grant.
- REQ-022: If multiple zones are pending at arbitration, the grant SHALL go to the first set bit scanning upward (mod 4) from last_grant+1.
- REQ-023: alarm SHALL assert on the same edge that any pending bit is set.
- REQ-024: The internal cycle timer SHALL be wide enough for max(DISCHARGE_CYCLES, COOLDOWN_CYCLES) and SHALL not wrap.
- REQ-025: At no time SHALL more than one valve bit be high.

Reset
- REQ-026: While reset=0, the outputs SHALL be extinguisher=0, valve=0, alarm=0 and pending=0; the FSM SHALL be in IDLE; the counters, timer and synchronizer SHALL be cleared; and the round-robin pointer SHALL be set so that zone 0 is next.
- REQ-027: Reset asserted mid-DISCHARGE SHALL drop extinguisher and valve immediately, without waiting for clk.
- REQ-028: After reset deasserts, a still-high sensor SHALL requalify through the full synchronizer + DEBOUNCE_CYCLES latency.

Configuration
- REQ-029: The feature macro SHALL be FIRE_SCHED_MANUAL_ACK_EN.
- REQ-030: With FIRE_SCHED_MANUAL_ACK_EN defined, alarm SHALL latch once set and clear only on a cycle where ack=1 and pending=0; ack while pending!=0 SHALL be ignored.
- REQ-031: Without FIRE_SCHED_MANUAL_ACK_EN, alarm SHALL clear on the edge after pending becomes 0, and the ack port SHALL be present but ignored.

Verification
- REQ-032: Scenario: fire_sensor=0001 held -> pending[0] set after 2 sync + 4 debounce cycles; OPEN for 1 cycle with valve=0001 and extinguisher=0; then 16 cycles of extinguisher=1; then 4 cooldown cycles.
- REQ-033: Scenario: 3-cycle pulse on zone 2 -> pending stays 0, alarm stays 0, no grant.
- REQ-034: Scenario: zones 1 and 3 qualify on the same cycle, last grant zone 1 -> zone 3 is served first, then zone 1; valve is never two-hot.
- REQ-035: Scenario: zone 0 sensor stays high through the discharge end -> pending[0] stays 1; after cooldown zone 0 is regranted if it is the only pending zone.
- REQ-036: Scenario: reset=0 at DISCHARGE cycle 8 -> extinguisher, valve and alarm are 0 before the next clk edge, and the FSM is in IDLE.
- REQ-037: Scenario, run both with and without FIRE_SCHED_MANUAL_ACK_EN: after service completes with sensors low, alarm clears automatically without the macro; with the macro it holds 1 until an ack=1 pulse arrives while pending=0.
